// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer handshakes, fifo write port and grant status of the write arbiter
interface fifo_wr_arbiter_if #(
    parameter int D_WD  = 16,
    parameter int N_REQ = 4
);
    localparam int ID_WD = $clog2(N_REQ);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ*D_WD-1:0] req_data;
    logic                  fifo_write;
    logic [D_WD-1:0]       fifo_data;
    logic                  fifo_full;
    logic                  grant_valid;
    logic [ID_WD-1:0]      grant_id;
    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_write, fifo_data, grant_valid, grant_id
    );
    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_write, fifo_data, grant_valid, grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one fifo write port among N_REQ producers
module fifo_wr_arbiter #(
    parameter int D_WD      = 16,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 4
) (
    input logic               clk,
    input logic               rst,
    fifo_wr_arbiter_if.master bus
);
    localparam int ID_WD = $clog2(N_REQ);
    typedef enum logic {IDLE, BURST} state_t;
    state_t           state, state_n;
    logic [ID_WD-1:0] g, g_n, rr, rr_n, pick, cand, g_inc;
    logic [7:0]       beat, beat_n;
    logic             busy, xfer;
    assign busy  = state == BURST;
    assign xfer  = busy && bus.req_valid[g] && !bus.fifo_full;
    assign g_inc = (int'(g) == N_REQ - 1) ? '0 : g + 1'b1;
    assign bus.req_ready   = (busy && !bus.fifo_full) ? N_REQ'(1) << g : '0;
    assign bus.fifo_write  = xfer;
    assign bus.fifo_data   = xfer ? bus.req_data[g*D_WD +: D_WD] : '0;
    assign bus.grant_valid = busy;
    assign bus.grant_id    = busy ? g : '0;
    // Scan downward so the requester closest to rr (wrapping) is the last to be written.
    always_comb begin
        pick = rr;
        cand = rr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ID_WD'((int'(rr) + i) % N_REQ);
            pick = bus.req_valid[cand] ? cand : pick;
        end
    end
    always_comb begin
        state_n = state;
        g_n     = g;
        beat_n  = beat;
        rr_n    = rr;
        if (state == IDLE) begin
            if (|bus.req_valid) begin
                state_n = BURST;
                g_n     = pick;
                beat_n  = '0;
            end
        end else if (!bus.req_valid[g] || (xfer && beat == 8'(MAX_BURST - 1))) begin
            state_n = IDLE;
            rr_n    = g_inc;
        end else if (xfer) begin
            beat_n = beat + 8'd1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            g     <= '0;
            beat  <= '0;
            rr    <= '0;
        end else begin
            state <= state_n;
            g     <= g_n;
            beat  <= beat_n;
            rr    <= rr_n;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: vector table, directed corner sequences and random traffic against a grant-record model
module tb_fifo_wr_arbiter;
    localparam int D_WD = 16, N = 4, MB = 4;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    fifo_wr_arbiter_if #(.D_WD(D_WD), .N_REQ(N)) bus();
    fifo_wr_arbiter #(.D_WD(D_WD), .N_REQ(N), .MAX_BURST(MB)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    int checks = 0, errors = 0;
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // model: owner = -1 when nobody holds the port, left = beats still allowed
    int owner, left, rr;
    int rem[N], sent[N];
    logic [N-1:0] pend;
    logic [D_WD-1:0] word[N];
    int val_pct, full_pct, cap, full_from, full_to, fcount;
    bit rnd_data, prev_gv;
    int dut_writes, stall, wr_full, glog[$];
    logic [D_WD-1:0] dlog[$];
    logic [31:0] wpat;

    task automatic reset_all();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        owner = -1; left = 0; rr = 0; pend = '0;
        for (int k = 0; k < N; k++) begin rem[k] = 0; sent[k] = 0; word[k] = '0; end
        val_pct = 100; full_pct = 0; cap = 1000000; full_from = -1; full_to = -1; rnd_data = 0;
    endtask

    task automatic run(input int ncyc);
        logic full;
        bit xfer;
        int xo;
        fcount = 0; dut_writes = 0; stall = 0; wr_full = 0; wpat = '0; prev_gv = 0;
        glog.delete(); dlog.delete();
        for (int c = 0; c < ncyc; c++) begin
            for (int k = 0; k < N; k++)
                if (!pend[k] && rem[k] > 0 && $urandom_range(99) < val_pct) begin
                    pend[k] = 1'b1;
                    word[k] = rnd_data ? D_WD'($urandom) : D_WD'(k * 256 + sent[k]);
                end
            bus.req_valid = pend;
            for (int k = 0; k < N; k++) bus.req_data[k*D_WD +: D_WD] = word[k];
            full = (fcount >= cap) || (c >= full_from && c < full_to) || ($urandom_range(99) < full_pct);
            bus.fifo_full = full;
            @(negedge clk);
            xo = owner;
            xfer = owner >= 0 && pend[owner] && !full;
            check("ready", bus.req_ready, (owner >= 0 && !full) ? (1 << owner) : 0);
            check("write", bus.fifo_write, xfer);
            check("data", bus.fifo_data, xfer ? word[owner] : 0);
            check("grant_valid", bus.grant_valid, owner >= 0);
            check("grant_id", bus.grant_id, owner < 0 ? 0 : owner);
            if (bus.grant_valid && !prev_gv) glog.push_back(bus.grant_id);
            prev_gv = bus.grant_valid;
            if (bus.fifo_write) begin dut_writes++; dlog.push_back(bus.fifo_data); end
            if (bus.fifo_write && bus.fifo_full) wr_full++;
            if (bus.grant_valid && bus.grant_id == 1 && !bus.fifo_write && bus.req_ready == 0) stall++;
            wpat = {wpat[30:0], bus.fifo_write};
            @(posedge clk);
            #1;
            if (owner < 0) begin
                for (int k = 0; k < N; k++)
                    if (owner < 0 && pend[(rr + k) % N]) begin owner = (rr + k) % N; left = MB; end
            end else if (!pend[owner]) begin
                rr = (owner + 1) % N; owner = -1;
            end else if (xfer) begin
                left--;
                if (left == 0) begin rr = (owner + 1) % N; owner = -1; end
            end
            if (xfer) begin pend[xo] = 1'b0; rem[xo]--; sent[xo]++; fcount++; end
        end
    endtask

    typedef struct {
        logic [3:0] valid;
        logic       full;
        logic [3:0] ready;
        logic       write;
        logic       gv;
        logic [1:0] gid;
    } vec_t;
    vec_t tv[12];

    initial begin
        tv[0]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tv[1]  = '{4'b1000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tv[2]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3};
        tv[3]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3};
        tv[4]  = '{4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 2'd3};
        tv[5]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tv[6]  = '{4'b0001, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        tv[7]  = '{4'b0001, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        tv[8]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};
        tv[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0};
        tv[10] = '{4'b0011, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0};
        tv[11] = '{4'b0011, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1};
        bus.req_valid = '1;
        bus.req_data = '1;
        bus.fifo_full = 1'b0;
        @(negedge clk);
        check("rst_ready", bus.req_ready, 0);
        check("rst_write", bus.fifo_write, 0);
        check("rst_data", bus.fifo_data, 0);
        check("rst_gv", bus.grant_valid, 0);
        check("rst_gid", bus.grant_id, 0);
        reset_all();
        for (int k = 0; k < N; k++) bus.req_data[k*D_WD +: D_WD] = D_WD'(16'hA0A0 + k);
        for (int i = 0; i < 12; i++) begin
            bus.req_valid = tv[i].valid;
            bus.fifo_full = tv[i].full;
            @(negedge clk);
            check($sformatf("tv%0d_ready", i), bus.req_ready, tv[i].ready);
            check($sformatf("tv%0d_write", i), bus.fifo_write, tv[i].write);
            check($sformatf("tv%0d_data", i), bus.fifo_data, tv[i].write ? 16'hA0A0 + tv[i].gid : 0);
            check($sformatf("tv%0d_gv", i), bus.grant_valid, tv[i].gv);
            check($sformatf("tv%0d_gid", i), bus.grant_id, tv[i].gid);
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b1;
        #1;
        check("async_ready", bus.req_ready, 0);
        check("async_write", bus.fifo_write, 0);
        check("async_gv", bus.grant_valid, 0);
        check("async_gid", bus.grant_id, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        bus.req_valid = 4'b0011;
        @(negedge clk);
        check("post_rst_idle", bus.grant_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_gv", bus.grant_valid, 1);
        check("post_rst_gid", bus.grant_id, 0);

        reset_all();
        rem[2] = 6;
        run(9);
        check("single_pattern", int'(wpat[8:0]), 9'b011110110);
        check("single_count", dlog.size(), 6);
        for (int i = 0; i < dlog.size(); i++) check($sformatf("single_order%0d", i), dlog[i], 512 + i);

        reset_all();
        for (int k = 0; k < N; k++) rem[k] = 8;
        run(40);
        check("all_writes", dut_writes, 32);
        check("all_grants", glog.size(), 8);
        for (int i = 0; i < glog.size(); i++) check($sformatf("all_grant%0d", i), glog[i], i % N);

        reset_all();
        rem[1] = 4; full_from = 2; full_to = 5;
        run(9);
        check("full_stall", stall, 3);
        check("full_writes", dut_writes, 4);

        reset_all();
        for (int k = 0; k < N; k++) rem[k] = 10;
        cap = 16;
        run(40);
        check("fill_writes", dut_writes, 16);
        check("fill_write_while_full", wr_full, 0);

        reset_all();
        for (int k = 0; k < N; k++) rem[k] = 1000;
        rnd_data = 1; val_pct = 40; full_pct = 20;
        run(3000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
